// File: rtl/mac_reduce_pkg.sv
// -----------------------------------------------------------------------------
// mac_reduce_pkg
// Shared constants, FIFO entry type and quantizer for mac_tile_reducer.
//
// Optional build macro: REDUCER_SAT_EN
//   defined   -> quantize() saturates to the signed DATA_WIDTH range
//   undefined -> quantize() keeps the low DATA_WIDTH bits (wraps)
// -----------------------------------------------------------------------------
package mac_reduce_pkg;

  localparam int TILE_SIZE  = 4;
  localparam int ACC_WIDTH  = 32;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int COL_BLOCKS = 64;
  localparam int ROW_TILES  = 64;

  // Row sum of TILE_SIZE elements, then COL_BLOCKS of those: widths grow
  // just enough that neither stage can overflow.
  localparam int SUM_W = ACC_WIDTH + $clog2(TILE_SIZE);
  localparam int ACC_W = SUM_W + $clog2(COL_BLOCKS);
  localparam int IDX_W = $clog2(ROW_TILES);
  localparam int CNT_W = $clog2(COL_BLOCKS);

  typedef struct packed {
    logic [TILE_SIZE*DATA_WIDTH-1:0] vec;
    logic [IDX_W-1:0]                idx;
  } fifo_entry_t;

`ifdef REDUCER_SAT_EN
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(2**(DATA_WIDTH-1) - 1);
  // Bitwise inverse of 0..0111..1 is 1..1000..0, i.e. -2^(DATA_WIDTH-1).
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;
`endif

  // Floor-shift by FRAC_BITS, then narrow to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic signed [ACC_W-1:0] total);
`ifdef REDUCER_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    shifted = total >>> FRAC_BITS;
    if (shifted > Q_MAX)      quantize = Q_MAX[DATA_WIDTH-1:0];
    else if (shifted < Q_MIN) quantize = Q_MIN[DATA_WIDTH-1:0];
    else                      quantize = shifted[DATA_WIDTH-1:0];
`else
    quantize = DATA_WIDTH'(total >>> FRAC_BITS);
`endif
  endfunction

endpackage

// File: rtl/reducer_out_fifo.sv
// -----------------------------------------------------------------------------
// reducer_out_fifo
// Two-entry output FIFO for reduced vectors.
//
// Handshake: the head is transferred on every edge where valid && ready are
// both high; valid never depends on ready, and head stays stable while valid
// is high and ready is low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush (empties FIFO, zeroes storage)
//   push         write push_data this cycle
//   push_data    entry to store
//   ready        downstream accepts the head
//   valid        head holds a valid entry
//   head         oldest entry
//   drop         push was refused because the FIFO was full and not popping
// -----------------------------------------------------------------------------
module reducer_out_fifo
  import mac_reduce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        ready,
  output logic        valid,
  output fifo_entry_t head,
  output logic        drop
);

  fifo_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign head    = mem[rd_ptr];
  assign do_pop  = valid && ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // take the new entry (wr_ptr == rd_ptr when full; old head is read out first).
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_tile_reducer.sv
// -----------------------------------------------------------------------------
// mac_tile_reducer
// Sums the rows of each incoming 4x4 MAC partial tile, accumulates the row sums
// over COL_BLOCKS beats, quantizes the result and queues it in a 2-entry FIFO.
// Also checks the compute pipeline's done_tile pulse against its own beat count.
//
// Optional build macro: REDUCER_SAT_EN (saturating quantization; default wraps).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mac_mode       compute pipeline is in MAC mode; low aborts a partial tile
//   clear          synchronous soft clear, highest priority
//   res_valid      tile beat present
//   res_tile       flattened tile, element [i][j] at (i*TILE_SIZE+j)*ACC_WIDTH
//   done_tile      tile-complete pulse to cross-check
//   out_valid      FIFO head valid
//   out_ready      downstream accepts head
//   out_vec        quantized lanes, lane i at i*DATA_WIDTH
//   out_idx        row-tile index of out_vec
//   err_overflow   sticky: vector dropped on full FIFO
//   err_sync       sticky: done_tile disagreed with beat count
// -----------------------------------------------------------------------------
module mac_tile_reducer
  import mac_reduce_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  mac_mode,
  input  logic                                  clear,
  input  logic                                  res_valid,
  input  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] res_tile,
  input  logic                                  done_tile,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [TILE_SIZE*DATA_WIDTH-1:0]       out_vec,
  output logic [IDX_W-1:0]                      out_idx,
  output logic                                  err_overflow,
  output logic                                  err_sync
);

  logic signed [SUM_W-1:0] rowsum    [TILE_SIZE];
  logic signed [SUM_W-1:0] s1_rowsum [TILE_SIZE];
  logic signed [ACC_W-1:0] acc       [TILE_SIZE];
  logic                    s1_valid;
  logic                    s1_last;
  logic [CNT_W-1:0]        beat_cnt;
  logic [IDX_W-1:0]        row_idx;
  logic                    beat_last;
  logic                    s2_push;
  fifo_entry_t             push_entry;
  fifo_entry_t             head;
  logic                    fifo_drop;

  // Stage-1 combinational row sums, each element sign-extended first.
  always_comb begin
    for (int i = 0; i < TILE_SIZE; i++) begin
      rowsum[i] = '0;
      for (int j = 0; j < TILE_SIZE; j++) begin
        rowsum[i] = rowsum[i]
                  + SUM_W'(signed'(res_tile[(i*TILE_SIZE+j)*ACC_WIDTH +: ACC_WIDTH]));
      end
    end
  end

  assign beat_last = (beat_cnt == CNT_W'(COL_BLOCKS-1));
  assign s2_push   = s1_valid && s1_last;

  // Final total for a last beat is acc plus the beat still in stage 1.
  always_comb begin
    push_entry = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      push_entry.vec[i*DATA_WIDTH +: DATA_WIDTH] = quantize(acc[i] + ACC_W'(s1_rowsum[i]));
    end
    push_entry.idx = row_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      row_idx      <= '0;
      err_overflow <= 1'b0;
      err_sync     <= 1'b0;
      for (int i = 0; i < TILE_SIZE; i++) begin
        s1_rowsum[i] <= '0;
        acc[i]       <= '0;
      end
    end else if (clear) begin
      beat_cnt     <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      row_idx      <= '0;
      err_overflow <= 1'b0;
      err_sync     <= 1'b0;
      for (int i = 0; i < TILE_SIZE; i++) begin
        s1_rowsum[i] <= '0;
        acc[i]       <= '0;
      end
    end else begin
      // Stage 1: leaving MAC mode abandons any partial tile.
      if (!mac_mode) begin
        beat_cnt <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= res_valid;
        if (res_valid) begin
          s1_last  <= beat_last;
          beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
          for (int i = 0; i < TILE_SIZE; i++) s1_rowsum[i] <= rowsum[i];
        end
      end

      // Stage 2: a fully sampled tile still completes even if mac_mode has
      // just dropped; otherwise a mode drop discards the partial sums.
      if (s2_push) begin
        for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
        row_idx <= (row_idx == IDX_W'(ROW_TILES-1)) ? '0 : row_idx + IDX_W'(1);
      end else if (!mac_mode) begin
        for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
      end else if (s1_valid) begin
        for (int i = 0; i < TILE_SIZE; i++) acc[i] <= acc[i] + ACC_W'(s1_rowsum[i]);
      end

      if (fifo_drop) err_overflow <= 1'b1;
      // done_tile must coincide exactly with a last beat sitting in stage 1.
      if (done_tile != s2_push) err_sync <= 1'b1;
    end
  end

  reducer_out_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (s2_push),
    .push_data (push_entry),
    .ready     (out_ready),
    .valid     (out_valid),
    .head      (head),
    .drop      (fifo_drop)
  );

  assign out_vec = head.vec;
  assign out_idx = head.idx;

endmodule

// File: tb/tb_mac_tile_reducer.sv
// -----------------------------------------------------------------------------
// tb_mac_tile_reducer
// Self-checking bench for mac_tile_reducer. Expected vectors are modelled from
// the driven tile elements and queued; a monitor pops and compares them on
// every accepted output beat.
// -----------------------------------------------------------------------------
module tb_mac_tile_reducer;

  localparam int TS = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int CB = 64;
  localparam int RT = 64;
  localparam int IW = 6;
  localparam int EW = TS*DW + IW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mac_mode = 1'b0;
  logic                  clear = 1'b0;
  logic                  res_valid = 1'b0;
  logic [TS*TS*AW-1:0]   res_tile = '0;
  logic                  done_tile = 1'b0;
  logic                  out_ready = 1'b0;
  logic                  out_valid;
  logic [TS*DW-1:0]      out_vec;
  logic [IW-1:0]         out_idx;
  logic                  err_overflow;
  logic                  err_sync;

  int checks = 0;
  int failures = 0;
  int exp_idx = 0;
  bit late_done = 1'b0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mac_tile_reducer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mac_mode     (mac_mode),
    .clear        (clear),
    .res_valid    (res_valid),
    .res_tile     (res_tile),
    .done_tile    (done_tile),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vec      (out_vec),
    .out_idx      (out_idx),
    .err_overflow (err_overflow),
    .err_sync     (err_sync)
  );

  // ---------------- reference quantizer ----------------
  function automatic logic [DW-1:0] model_q(input longint total);
    longint s;
    s = total >>> FB;
`ifdef REDUCER_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[DW-1:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && !clear && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got vec=%h idx=%0d, required no output", out_vec, out_idx);
      end else begin
        e = exp_q.pop_front();
        if ({out_vec, out_idx} !== e) begin
          failures++;
          $display("FAIL out_beat: got vec=%h idx=%0d, required vec=%h idx=%0d",
                   out_vec, out_idx, e[EW-1:IW], e[IW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // kind 0: every element = cval; kind 1: random elements in [-65536, 65535].
  task automatic send_vector(input int kind, input logic [AW-1:0] cval,
                             input bit expect_drop, input bit check_lat,
                             input bit ready_at_last);
    longint            tot [TS];
    logic [TS*TS*AW-1:0] t;
    logic [AW-1:0]     v;
    logic [TS*DW-1:0]  vec;
    for (int i = 0; i < TS; i++) tot[i] = 0;
    for (int b = 0; b < CB; b++) begin
      for (int e = 0; e < TS*TS; e++) begin
        v = (kind == 0) ? cval : (AW'($urandom_range(0, 131071)) - 32'd65536);
        t[e*AW +: AW] = v;
        tot[e/TS] += longint'(signed'(v));
      end
      res_tile  = t;
      res_valid = 1'b1;
      done_tile = 1'b0;
      @(posedge clk); #1;
    end
    // Last beat has just been sampled.
    res_valid = 1'b0;
    done_tile = !late_done;
    for (int i = 0; i < TS; i++) vec[i*DW +: DW] = model_q(tot[i]);
    if (!expect_drop) exp_q.push_back({vec, IW'(exp_idx)});
    exp_idx = (exp_idx + 1) % RT;
    if (ready_at_last) out_ready = 1'b1;
    if (check_lat) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL latency_early: out_valid=%b one edge after last beat, required 0", out_valid);
      end
    end
    @(posedge clk); #1;
    done_tile = late_done;
    if (check_lat) begin
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL latency_rise: out_valid=%b two edges after last beat, required 1", out_valid);
      end
    end
    @(posedge clk); #1;
    done_tile = 1'b0;
  endtask

  task automatic wait_drain();
    bit drained;
    drained = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && out_valid === 1'b0) begin
        drained = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL drain_timeout: %0d vectors still expected, out_valid=%b, required drained",
               exp_q.size(), out_valid);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    exp_idx = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++; if (out_vec !== '0) begin failures++; $display("FAIL reset_vec: got %h required 0", out_vec); end
    checks++; if (out_idx !== '0) begin failures++; $display("FAIL reset_idx: got %0d required 0", out_idx); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", err_overflow); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL reset_sync: got %b required 0", err_sync); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    mac_mode  = 1'b1;
    out_ready = 1'b1;
    send_vector(0, 32'd256, 1'b0, 1'b1, 1'b0);
    wait_drain();
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b required 0", err_overflow); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL basic_sync: got %b required 0", err_sync); end
  endtask

  task automatic test_extreme();
    send_vector(0, 32'h7FFF_0000, 1'b0, 1'b0, 1'b0);
    send_vector(0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL extreme_sync: got %b required 0", err_sync); end
  endtask

  task automatic test_mac_mode();
    logic [TS*TS*AW-1:0] t;
    for (int b = 0; b < 30; b++) begin
      for (int e = 0; e < TS*TS; e++) t[e*AW +: AW] = $urandom;
      res_tile = t; res_valid = 1'b1;
      @(posedge clk); #1;
    end
    mac_mode = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int e = 0; e < TS*TS; e++) t[e*AW +: AW] = $urandom;
      res_tile = t;
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    mac_mode  = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mode_partial_out: out_valid=%b required 0", out_valid); end
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL mode_sync: got %b required 0", err_sync); end
  endtask

  task automatic test_sync_clear();
    logic [EW-1:0] e;
    out_ready = 1'b0;
    late_done = 1'b1;
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    late_done = 1'b0;
    e = exp_q[0];
    checks++; if (err_sync !== 1'b1) begin failures++; $display("FAIL sync_flag: got %b required 1", err_sync); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sync_valid: got %b required 1", out_valid); end
    checks++;
    if ({out_vec, out_idx} !== e) begin
      failures++;
      $display("FAIL sync_data: got vec=%h idx=%0d required vec=%h idx=%0d",
               out_vec, out_idx, e[EW-1:IW], e[IW-1:0]);
    end
    do_clear();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clear_valid: got %b required 0", out_valid); end
    checks++; if (out_idx !== '0) begin failures++; $display("FAIL clear_idx: got %0d required 0", out_idx); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL clear_sync: got %b required 0", err_sync); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL clear_ovf: got %b required 0", err_overflow); end
    out_ready = 1'b1;
  endtask

  task automatic test_overflow();
    logic [EW-1:0] e;
    out_ready = 1'b0;
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    send_vector(1, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b required 1", err_overflow); end
    e = exp_q[0];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_vec, out_idx} !== e) begin
        failures++;
        $display("FAIL ovf_hold: valid=%b vec=%h idx=%0d required valid=1 vec=%h idx=%0d",
                 out_valid, out_vec, out_idx, e[EW-1:IW], e[IW-1:0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", err_overflow); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b0;
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    // Third vector lands while full, in the same edge as a pop.
    send_vector(1, '0, 1'b0, 1'b0, 1'b1);
    wait_drain();
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b required 0", err_overflow); end
  endtask

  task automatic test_wrap();
    do_clear();
    out_ready = 1'b1;
    for (int v = 0; v < RT + 1; v++) send_vector(1, '0, 1'b0, 1'b0, 1'b0);
    wait_drain();
    checks++; if (exp_idx !== 1) begin failures++; $display("FAIL wrap_model_idx: got %0d required 1", exp_idx); end
    checks++; if (err_overflow !== 1'b0 || err_sync !== 1'b0) begin
      failures++; $display("FAIL wrap_flags: ovf=%b sync=%b required 0 0", err_overflow, err_sync);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_mac_mode();
    test_sync_clear();
    test_overflow();
    test_back_to_back();
    test_wrap();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
